io_mailbox: RTL and testbench

I/O-bus responder that sits on the CPU's port-mapped I/O interface, at the opposite end of the CPU's io_oe/io_we/io_port/io_in/io_out signals. It decodes CPU port accesses into a small register window, which holds a CPU-to-host TX FIFO, a host-to-CPU RX FIFO, a status register and a control register. An external host drains and fills the FIFOs through valid/ready streams.

---
 rtl/io_mailbox_if.sv | 25 ++
 rtl/io_mailbox.sv | 109 ++++++++++
 tb/tb_io_mailbox.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/io_mailbox_if.sv
// io_mailbox_if: CPU port-mapped I/O bus plus host TX/RX valid/ready streams.
interface io_mailbox_if #(
    parameter int word_width = 16,
    parameter int port_width = 8
);
    logic                  io_oe;
    logic                  io_we;
    logic [port_width-1:0] io_port;
    logic [word_width-1:0] io_in;
    logic [word_width-1:0] io_out;
    logic [word_width-1:0] host_tx_data;
    logic                  host_tx_valid;
    logic                  host_tx_ready;
    logic [word_width-1:0] host_rx_data;
    logic                  host_rx_valid;
    logic                  host_rx_ready;
    modport master (
        output io_oe, io_we, io_port, io_in, host_tx_ready, host_rx_data, host_rx_valid,
        input  io_out, host_tx_data, host_tx_valid, host_rx_ready
    );
    modport slave (
        input  io_oe, io_we, io_port, io_in, host_tx_ready, host_rx_data, host_rx_valid,
        output io_out, host_tx_data, host_tx_valid, host_rx_ready
    );
endinterface

// File: rtl/io_mailbox.sv
// io_mailbox: port-I/O register window (DATA/STATUS/CTRL) fronting a CPU->host TX FIFO
// and a host->CPU RX FIFO.
module io_mailbox #(
    parameter int                    word_width = 16,
    parameter int                    port_width = 8,
    parameter logic [port_width-1:0] base_addr  = 8'h10,
    parameter int                    depth_log2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    io_mailbox_if.slave bus
);
    localparam int depth = 1 << depth_log2;
    localparam int cw = depth_log2 + 1;
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    logic [word_width-1:0] r_tx_mem [depth];
    logic [word_width-1:0] r_rx_mem [depth];
    logic [depth_log2-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [cw-1:0]         r_tx_cnt, r_rx_cnt;
    logic                  r_tx_en, r_rx_ovf, r_tx_ovf, r_rx_unf;

    logic [port_width-1:0] w_off;
    logic                  w_sel, w_data, w_stat, w_ctrl, w_stat_wr;
    logic                  w_tx_full, w_rx_empty, w_tx_valid, w_rx_ready;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_flush;
    logic                  w_tx_ovf_set, w_rx_unf_set, w_rx_ovf_set;
    logic [15:0]           w_status;

    assign w_off  = bus.io_port - base_addr;
    assign w_sel  = w_off < port_width'(3);
    assign w_data = w_sel && w_off[1:0] == 2'd0;
    assign w_stat = w_sel && w_off[1:0] == 2'd1;
    assign w_ctrl = w_sel && w_off[1:0] == 2'd2;
    assign w_stat_wr = bus.io_we && w_stat;

    assign w_tx_full  = r_tx_cnt == full_cnt;
    assign w_rx_empty = r_rx_cnt == '0;
    assign w_tx_valid = r_tx_cnt != '0 && r_tx_en;
    assign w_rx_ready = r_rx_cnt != full_cnt;

    // Full/empty decisions below all use pre-edge counts; flush overrides every push/pop.
    assign w_flush      = bus.io_we && w_ctrl && bus.io_in[1];
    assign w_tx_push    = bus.io_we && w_data && !w_tx_full;
    assign w_tx_ovf_set = bus.io_we && w_data && w_tx_full;
    assign w_tx_pop     = w_tx_valid && bus.host_tx_ready;
    assign w_rx_push    = bus.host_rx_valid && w_rx_ready;
    assign w_rx_pop     = bus.io_oe && w_data && !w_rx_empty;
    assign w_rx_unf_set = bus.io_oe && w_data && w_rx_empty;
    assign w_rx_ovf_set = w_flush && w_rx_push;

    assign w_status = {4'(r_tx_cnt), 4'(r_rx_cnt), 3'b000, r_rx_unf, r_tx_ovf, r_rx_ovf,
                       w_tx_full, !w_rx_empty};

    assign bus.host_tx_valid = w_tx_valid;
    assign bus.host_rx_ready = w_rx_ready;
    assign bus.host_tx_data  = r_tx_mem[r_tx_rp];
    assign bus.io_out = !bus.io_oe ? '0 :
                        w_data     ? (w_rx_empty ? '0 : r_rx_mem[r_rx_rp]) :
                        w_stat     ? word_width'(w_status) :
                        w_ctrl     ? word_width'(r_tx_en) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                r_tx_mem[i] <= '0;
                r_rx_mem[i] <= '0;
            end
        end else begin
            if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.io_in;
            if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.host_rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_tx_en  <= 1'b1;
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
        end else begin
            r_rx_ovf <= w_rx_ovf_set || (r_rx_ovf && !(w_stat_wr && bus.io_in[2]));
            r_tx_ovf <= w_tx_ovf_set || (r_tx_ovf && !(w_stat_wr && bus.io_in[3]));
            r_rx_unf <= w_rx_unf_set || (r_rx_unf && !(w_stat_wr && bus.io_in[4]));
            if (bus.io_we && w_ctrl) r_tx_en <= bus.io_in[0];
            if (w_flush) begin
                r_tx_wp  <= '0;
                r_tx_rp  <= '0;
                r_rx_wp  <= '0;
                r_rx_rp  <= '0;
                r_tx_cnt <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + depth_log2'(1);
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + depth_log2'(1);
                if (w_rx_push) r_rx_wp <= r_rx_wp + depth_log2'(1);
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + depth_log2'(1);
                r_tx_cnt <= r_tx_cnt + cw'(w_tx_push) - cw'(w_tx_pop);
                r_rx_cnt <= r_rx_cnt + cw'(w_rx_push) - cw'(w_rx_pop);
            end
        end
    end
endmodule

// File: tb/tb_io_mailbox.sv
// tb_io_mailbox: directed and randomized checks of io_mailbox against a queue-based model.
module tb_io_mailbox;
    logic clk = 1'b0;
    logic rst_n;
    int   errs = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    io_mailbox_if #(.word_width(16), .port_width(8)) bus();
    io_mailbox dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    bit tx_en, rx_ovf, tx_ovf, rx_unf;

    logic [7:0] m_o;
    bit m_wr, m_rd, m_fl, m_txp, m_rxp, m_txf, m_rxe;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] status();
        return {4'(tx_q.size()), 4'(rx_q.size()), 3'b000, rx_unf, tx_ovf, rx_ovf,
                (tx_q.size() == 8), (rx_q.size() != 0)};
    endfunction

    function automatic logic [15:0] exp_out();
        logic [7:0] o;
        o = bus.io_port - 8'h10;
        if (!bus.io_oe || o > 8'd2) return 16'h0;
        if (o == 8'd0) return rx_q.size() != 0 ? rx_q[0] : 16'h0;
        if (o == 8'd1) return status();
        return {15'b0, tx_en};
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        tx_en = 1'b1;
        rx_ovf = 1'b0;
        tx_ovf = 1'b0;
        rx_unf = 1'b0;
    endtask

    task automatic set_idle();
        bus.io_oe = 0; bus.io_we = 0; bus.io_port = '0; bus.io_in = '0;
        bus.host_tx_ready = 0; bus.host_rx_valid = 0; bus.host_rx_data = '0;
    endtask

    task automatic drive(bit oe, bit we, logic [7:0] port, logic [15:0] din,
                         bit txr, bit rxv, logic [15:0] rxd);
        @(negedge clk);
        bus.io_oe = oe; bus.io_we = we; bus.io_port = port; bus.io_in = din;
        bus.host_tx_ready = txr; bus.host_rx_valid = rxv; bus.host_rx_data = rxd;
    endtask

    // Compare outputs for the cycle, then advance the model across the coming edge.
    always @(negedge clk) if (chk_en) begin
        #1;
        chk("io_out", bus.io_out, exp_out());
        chk("tx_valid", bus.host_tx_valid, tx_q.size() != 0 && tx_en);
        chk("rx_ready", bus.host_rx_ready, rx_q.size() < 8);
        if (tx_q.size() != 0) chk("tx_data", bus.host_tx_data, tx_q[0]);
        m_o   = bus.io_port - 8'h10;
        m_wr  = bus.io_we && m_o < 8'd3;
        m_rd  = bus.io_oe && m_o < 8'd3;
        m_fl  = m_wr && m_o == 8'd2 && bus.io_in[1];
        m_txp = bus.host_tx_ready && tx_q.size() != 0 && tx_en;
        m_rxp = bus.host_rx_valid && rx_q.size() < 8;
        m_txf = tx_q.size() == 8;
        m_rxe = rx_q.size() == 0;
        if (m_wr && m_o == 8'd1) begin
            if (bus.io_in[2]) rx_ovf = 1'b0;
            if (bus.io_in[3]) tx_ovf = 1'b0;
            if (bus.io_in[4]) rx_unf = 1'b0;
        end
        if (m_wr && m_o == 8'd0 && m_txf) tx_ovf = 1'b1;
        if (m_rd && m_o == 8'd0 && m_rxe) rx_unf = 1'b1;
        if (m_fl && m_rxp) rx_ovf = 1'b1;
        if (m_wr && m_o == 8'd2) tx_en = bus.io_in[0];
        if (m_fl) begin
            tx_q.delete();
            rx_q.delete();
        end else begin
            if (m_txp) void'(tx_q.pop_front());
            if (m_wr && m_o == 8'd0 && !m_txf) tx_q.push_back(bus.io_in);
            if (m_rd && m_o == 8'd0 && !m_rxe) void'(rx_q.pop_front());
            if (m_rxp) rx_q.push_back(bus.host_rx_data);
        end
    end

    initial begin
        int r;
        logic [7:0] p;
        logic [15:0] d;
        bit hi;
        set_idle();
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_io_out", bus.io_out, 16'h0);
        chk("rst_tx_valid", bus.host_tx_valid, 1'b0);
        chk("rst_rx_ready", bus.host_rx_ready, 1'b1);
        chk("rst_tx_data", bus.host_tx_data, 16'h0);
        @(negedge clk);
        #2 rst_n = 1'b1; chk_en = 1'b1;
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("rst_status", bus.io_out, 16'h0000);
        drive(1, 0, 8'h12, 0, 0, 0, 0);
        #2 chk("rst_ctrl", bus.io_out, 16'h0001);

        drive(0, 1, 8'h10, 16'hA5A5, 0, 0, 0);
        drive(0, 1, 8'h10, 16'h1234, 0, 0, 0);
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("tx2_status", bus.io_out, 16'h2000);
        drive(0, 0, 8'h00, 0, 1, 0, 0);
        #2 chk("tx2_first", bus.host_tx_data, 16'hA5A5);
        drive(0, 0, 8'h00, 0, 1, 0, 0);
        #2 chk("tx2_second", bus.host_tx_data, 16'h1234);
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        #2 chk("tx2_empty", bus.host_tx_valid, 1'b0);

        for (int i = 1; i <= 9; i++) drive(0, 1, 8'h10, 16'(i * 16'h0101), 0, 0, 0);
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("tx9_status", bus.io_out, 16'h800A);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 8'h00, 0, 1, 0, 0);
            #2 chk("tx9_drain", bus.host_tx_data, 16'(i * 16'h0101));
        end
        drive(0, 1, 8'h11, 16'h0008, 0, 0, 0);

        for (int i = 0; i < 8; i++) drive(0, 0, 8'h00, 0, 0, 1, 16'(16'hB000 + i));
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        #2 chk("rx8_ready", bus.host_rx_ready, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 8'h10, 0, 0, 0, 0);
            #2 chk("rx8_read", bus.io_out, i < 8 ? 16'(16'hB000 + i) : 16'h0);
        end
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("rx_unf_status", bus.io_out, 16'h0010);
        drive(0, 1, 8'h11, 16'h0010, 0, 0, 0);
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("rx_unf_clear", bus.io_out, 16'h0000);

        for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 0, 0, 1, 16'(16'hC000 + i));
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 8'h10, 0, 0, 1, 16'(16'hC003 + i));
            #2 chk("rx_pushpop", bus.io_out, 16'(16'hC000 + i));
        end
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("rx_pushpop_status", bus.io_out, 16'h0301);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h10, 0, 0, 0, 0);
            #2 chk("rx_wrap_tail", bus.io_out, 16'(16'hC008 + i));
        end

        drive(0, 0, 8'h00, 0, 0, 1, 16'h6001);
        drive(0, 1, 8'h10, 16'h7001, 0, 1, 16'h6002);
        drive(0, 1, 8'h10, 16'h7002, 0, 0, 0);
        drive(0, 1, 8'h12, 16'h0003, 1, 1, 16'hDEAD);
        #2 chk("flush_tx_head", bus.host_tx_data, 16'h7001);
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("flush_status", bus.io_out, 16'h0004);
        drive(0, 1, 8'h11, 16'h0004, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            hi = ((n / 300) % 2) == 1;
            r = $urandom_range(0, 99);
            p = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h10 + 8'($urandom_range(0, 2));
            d = 16'($urandom);
            if (p == 8'h12 && $urandom_range(0, 9) != 0) d[1] = 1'b0;
            if (p == 8'h12 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            drive(r < 35, r >= 30 && r < 70, p, d,
                  $urandom_range(0, 9) < (hi ? 8 : 2), $urandom_range(0, 9) < (hi ? 2 : 7),
                  16'($urandom));
        end

        drive(0, 1, 8'h10, 16'h4444, 0, 1, 16'h5151);
        drive(0, 1, 8'h10, 16'h4445, 0, 1, 16'h5252);
        drive(1, 0, 8'h10, 0, 1, 1, 16'h5555);
        #3 chk_en = 1'b0; rst_n = 1'b0;
        #1;
        chk("async_io_out", bus.io_out, 16'h0);
        chk("async_tx_valid", bus.host_tx_valid, 1'b0);
        chk("async_rx_ready", bus.host_rx_ready, 1'b1);
        chk("async_tx_data", bus.host_tx_data, 16'h0);
        model_reset();
        set_idle();
        @(negedge clk);
        #2 rst_n = 1'b1; chk_en = 1'b1;
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        #2 chk("post_rst_status", bus.io_out, 16'h0000);
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
